// File: rtl/layer_engine_if.sv
// Sequencer <-> layer engine bundle: step/clear controls, weight and
// activation read data, and the result write port toward the next-layer
// buffer. The sequencer side uses master, the engine uses slave.
`timescale 1ns/1ps

interface layer_engine_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 12
);
  logic                     layerrst;
  logic [3:0]               layerindex;
  logic [ADDR_W-1:0]        addr;
  logic [CNT_W-1:0]         fanin;
  logic [CNT_W-1:0]         fanout;
  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] act;
  logic [CNT_W-1:0]         act_addr;
  logic                     out_we;
  logic [CNT_W-1:0]         out_addr;
  logic signed [DATA_W-1:0] out_data;
  logic [3:0]               out_layer;
  logic                     done;
  logic                     seq_err;

  modport master (
    output layerrst, layerindex, addr, fanin, fanout, weight, act,
    input  act_addr, out_we, out_addr, out_data, out_layer, done, seq_err
  );

  modport slave (
    input  layerrst, layerindex, addr, fanin, fanout, weight, act,
    output act_addr, out_we, out_addr, out_data, out_layer, done, seq_err
  );
endinterface

// File: rtl/layer_engine.sv
// Per-layer MAC engine. Consumes one weight/activation pair per cycle while
// the sequencer steps, accumulates each neuron's dot product, writes the
// scaled and saturated result, and raises done after the last neuron.
// Build option: define LAYER_ENGINE_RELU_EN to clamp negative results to 0.
`timescale 1ns/1ps

module layer_engine #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 4,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 12
) (
  input logic           clk,
  input logic           rst,
  layer_engine_if.slave bus
);

  // CLR doubles as the issue slot for pair 0 on the first cycle the
  // sequencer releases layerrst, so pair 0 meets addr 0.
  typedef enum logic [1:0] {CLR, ISSUE, DRAIN, FIN} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  state_t state, state_next;

  logic [CNT_W-1:0]  fanin_q, fanout_q;
  logic [CNT_W-1:0]  in_iss, neu_iss;
  logic [ADDR_W-1:0] step_cnt;

  // One-cycle pipe describing the pair whose data arrives this cycle.
  logic             valid_d, first_d, last_d;
  logic [CNT_W-1:0] neu_d;

  logic signed [ACC_W-1:0] acc;
  logic                    out_we_q;
  logic [CNT_W-1:0]        out_addr_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic [3:0]              out_layer_q;
  logic                    seq_err_q;

  logic empty, last_in, last_pair, issue;
  logic signed [DATA_W-1:0]   w_s, a_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_next, shifted;
  logic signed [DATA_W-1:0]   out_val;

  assign empty     = (fanin_q == '0) || (fanout_q == '0);
  assign last_in   = (in_iss == fanin_q - CNT_W'(1));
  assign last_pair = last_in && (neu_iss == fanout_q - CNT_W'(1));

  assign w_s      = bus.weight;
  assign a_s      = bus.act;
  assign prod     = w_s * a_s;
  assign acc_next = (first_d ? '0 : acc) + ACC_W'(prod);
  assign shifted  = acc_next >>> FRAC_BITS;

  // Output stage: saturate the scaled sum to the data range (and clamp
  // negatives when the ReLU build option is on).
  always_comb begin
    if (shifted > SAT_MAX)      out_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) out_val = SAT_MIN[DATA_W-1:0];
    else                        out_val = shifted[DATA_W-1:0];
`ifdef LAYER_ENGINE_RELU_EN
    if (shifted[ACC_W-1]) out_val = '0;
`endif
  end

  // Next-state and issue decode; layerrst overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_next = state;
    issue      = 1'b0;
    case (state)
      CLR: begin
        if (empty) begin
          state_next = DRAIN;
        end else begin
          issue      = 1'b1;
          state_next = last_pair ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_pair) state_next = DRAIN;
      end
      DRAIN:   if (!valid_d) state_next = FIN;
      FIN:     state_next = FIN;
      default: state_next = CLR;
    endcase
    if (bus.layerrst) begin
      state_next = CLR;
      issue      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    if (rst) state <= CLR;
    else     state <= state_next;
  end

  // Issue counters, accumulate pipe, result register and step checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fanin_q     <= '0;
      fanout_q    <= '0;
      in_iss      <= '0;
      neu_iss     <= '0;
      step_cnt    <= '0;
      valid_d     <= 1'b0;
      first_d     <= 1'b0;
      last_d      <= 1'b0;
      neu_d       <= '0;
      acc         <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_layer_q <= '0;
      seq_err_q   <= 1'b0;
    end else if (bus.layerrst) begin
      fanin_q    <= bus.fanin;
      fanout_q   <= bus.fanout;
      in_iss     <= '0;
      neu_iss    <= '0;
      step_cnt   <= '0;
      valid_d    <= 1'b0;
      first_d    <= 1'b0;
      last_d     <= 1'b0;
      neu_d      <= '0;
      acc        <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      valid_d  <= issue;
      first_d  <= (in_iss == '0);
      last_d   <= last_in;
      neu_d    <= neu_iss;
      out_we_q <= 1'b0;
      if (issue) begin
        step_cnt <= step_cnt + ADDR_W'(1);
        if (bus.addr != step_cnt) seq_err_q <= 1'b1;
        if (last_in) begin
          in_iss  <= '0;
          neu_iss <= neu_iss + CNT_W'(1);
        end else begin
          in_iss <= in_iss + CNT_W'(1);
        end
      end
      if (valid_d) begin
        acc <= acc_next;
        if (last_d) begin
          out_we_q    <= 1'b1;
          out_addr_q  <= neu_d;
          out_data_q  <= out_val;
          out_layer_q <= bus.layerindex;
        end
      end
    end
  end

  assign bus.act_addr  = in_iss;
  assign bus.out_we    = out_we_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_layer = out_layer_q;
  assign bus.done      = (state == FIN);
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_layer_engine.sv
// Bench for layer_engine: plays the layer sequencer (layerrst/addr stepping),
// models the weight ROM and activation buffer with one-cycle read latency,
// and scores every result write against a queue of expected writes.
`timescale 1ns/1ps

module tb_layer_engine;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 24;
  localparam int FRAC_BITS = 4;
  localparam int CNT_W     = 8;
  localparam int ADDR_W    = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_engine_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus();

  layer_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS),
    .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [DATA_W-1:0] wrom [0:(1<<ADDR_W)-1];
  logic signed [DATA_W-1:0] abuf [0:(1<<CNT_W)-1];

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    bus.weight <= wrom[bus.addr];
    bus.act    <= abuf[bus.act_addr];
  end

  typedef struct {
    logic [CNT_W-1:0]         addr;
    logic signed [DATA_W-1:0] data;
    logic [3:0]               layer;
    int                       cyc;
  } exp_t;

  typedef struct {
    logic signed [DATA_W-1:0] w0, w1, a0, a1;
    logic signed [DATA_W-1:0] exp_sat, exp_relu;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_seq_err = 1'b0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic signed [DATA_W-1:0] model_out(input int n, input int fi);
    logic signed [ACC_W-1:0] s;
    int v;
    s = '0;
    for (int i = 0; i < fi; i++)
      s = s + ACC_W'(int'(wrom[n*fi+i]) * int'(abuf[i]));
    v = int'(s) >>> FRAC_BITS;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`ifdef LAYER_ENGINE_RELU_EN
    if (v < 0) v = 0;
`endif
    return DATA_W'(v);
  endfunction

  task automatic push_exp(input int n, input logic signed [DATA_W-1:0] d,
                          input int li, input int fi);
    exp_t e;
    e.addr  = CNT_W'(n);
    e.data  = d;
    e.layer = 4'(li);
    e.cyc   = fi * (n + 1) + 1;
    sb.push_back(e);
  endtask

  task automatic push_model(input int fi, input int fo, input int li);
    for (int n = 0; n < fo; n++) push_exp(n, model_out(n, fi), li, fi);
  endtask

  task automatic load_rand(input int fi, input int fo);
    for (int p = 0; p < fi * fo; p++) wrom[p] = DATA_W'(int'($urandom_range(0, 40)) - 20);
    for (int i = 0; i < fi; i++)      abuf[i] = DATA_W'(int'($urandom_range(0, 80)) - 40);
  endtask

  // Runs one layer as the sequencer would. Entry/exit: at a negedge with
  // layerrst high. Cycle k is observed at the negedge after the k-th rising
  // edge that sampled layerrst low. abort_at/skip_at/rst_at < 0 disable.
  task automatic run_layer(input int fi, input int fo, input int li,
                           input int abort_at, input int skip_at, input int rst_at,
                           output int writes);
    int  n;
    bit  stop;
    exp_t e;
    n      = fi * fo;
    stop   = 1'b0;
    writes = 0;
    bus.fanin      = CNT_W'(fi);
    bus.fanout     = CNT_W'(fo);
    bus.layerindex = 4'(li);
    @(posedge clk); @(negedge clk);
    bus.layerrst = 1'b0;
    bus.addr     = '0;
    for (int k = 1; k <= n + 4 && !stop; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.out_we) begin
        writes++;
        if (skip_at < 0) begin
          if (sb.size() == 0) begin
            check("unexpected_out_we", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_addr", bus.out_addr, e.addr);
            check("out_data", bus.out_data, e.data);
            check("out_layer", bus.out_layer, e.layer);
            check("out_we_cycle", k, e.cyc);
          end
        end
      end
      check("done_timing", bus.done, (k >= n + 2));
      if (rst_at == k) begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_we", bus.out_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_layer", bus.out_layer, 0);
        check("rst_act_addr", bus.act_addr, 0);
        check("rst_seq_err", bus.seq_err, 0);
        sb.delete();
        exp_seq_err = 1'b0;
        @(negedge clk);
        bus.layerrst = 1'b1;
        rst = 1'b0;
        stop = 1'b1;
      end else if (abort_at == k) begin
        bus.layerrst = 1'b1;
        stop = 1'b1;
      end else begin
        bus.addr = ADDR_W'((skip_at >= 0 && k >= skip_at) ? k + 1 : k);
      end
    end
    if (rst_at < 0) begin
      check("scoreboard_empty", sb.size(), 0);
      check("seq_err", bus.seq_err, exp_seq_err);
      bus.layerrst = 1'b1;
      for (int j = 0; j < 2; j++) begin
        @(posedge clk); @(negedge clk);
        check("done_after_layerrst", bus.done, 0);
        check("out_we_after_layerrst", bus.out_we, 0);
      end
      check("seq_err_hold", bus.seq_err, exp_seq_err);
    end
  endtask

  vec_t vecs [10];
  int   w, total;

  initial begin
    vecs = '{
      '{127, 127, 127, 127, 127, 127},
      '{-128, -128, 127, 127, -128, 0},
      '{1, 2, 16, 32, 5, 5},
      '{-1, -2, 16, 32, -5, 0},
      '{-3, 0, 5, 0, -1, 0},
      '{64, 0, 32, 0, 127, 127},
      '{127, 0, 16, 0, 127, 127},
      '{-128, 0, 16, 0, -128, 0},
      '{-86, 0, 24, 0, -128, 0},
      '{15, 1, 1, 0, 0, 0}
    };
    for (int i = 0; i < (1 << ADDR_W); i++) wrom[i] = '0;
    for (int i = 0; i < (1 << CNT_W); i++)  abuf[i] = '0;

    rst            = 1'b1;
    bus.layerrst   = 1'b1;
    bus.layerindex = '0;
    bus.addr       = '0;
    bus.fanin      = '0;
    bus.fanout     = '0;
    repeat (2) @(negedge clk);
    check("reset_out_we", bus.out_we, 0);
    check("reset_done", bus.done, 0);
    check("reset_seq_err", bus.seq_err, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_act_addr", bus.act_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Worked example: 3 inputs x 2 neurons, writes at cycles 4 and 7.
    for (int p = 0; p < 6; p++) wrom[p] = DATA_W'(p + 1);
    abuf[0] = 16; abuf[1] = 32; abuf[2] = 48;
    push_exp(0, 14, 0, 3);
    push_exp(1, 32, 0, 3);
    run_layer(3, 2, 0, -1, -1, -1, w);
    check("example_writes", w, 2);

    // Saturation / rounding table, one 2-input neuron per row.
    foreach (vecs[i]) begin
      wrom[0] = vecs[i].w0; wrom[1] = vecs[i].w1;
      abuf[0] = vecs[i].a0; abuf[1] = vecs[i].a1;
`ifdef LAYER_ENGINE_RELU_EN
      push_exp(0, vecs[i].exp_relu, 1, 2);
`else
      push_exp(0, vecs[i].exp_sat, 1, 2);
`endif
      run_layer(2, 1, 1, -1, -1, -1, w);
    end

    // Empty layers: no writes, done two cycles after release.
    run_layer(0, 5, 2, -1, -1, -1, w);
    check("fanin0_writes", w, 0);
    run_layer(3, 0, 2, -1, -1, -1, w);
    check("fanout0_writes", w, 0);

    // Single-input neurons write back-to-back.
    load_rand(1, 4);
    push_model(1, 4, 5);
    run_layer(1, 4, 5, -1, -1, -1, w);
    check("fanin1_writes", w, 4);

    // Aborts: mid-neuron, and with a final product in flight.
    load_rand(4, 2);
    run_layer(4, 2, 6, 2, -1, -1, w);
    check("abort_mid_writes", w, 0);
    run_layer(1, 3, 6, 1, -1, -1, w);
    check("abort_inflight_writes", w, 0);
    push_model(4, 2, 7);
    run_layer(4, 2, 7, -1, -1, -1, w);
    check("after_abort_writes", w, 2);

    // Sequencer skips an address: sticky error.
    load_rand(2, 2);
    exp_seq_err = 1'b1;
    run_layer(2, 2, 8, -1, 2, -1, w);

    // Three layers back to back.
    total = 0;
    load_rand(4, 3); push_model(4, 3, 0); run_layer(4, 3, 0, -1, -1, -1, w); total += w;
    load_rand(3, 2); push_model(3, 2, 1); run_layer(3, 2, 1, -1, -1, -1, w); total += w;
    load_rand(2, 1); push_model(2, 1, 2); run_layer(2, 1, 2, -1, -1, -1, w); total += w;
    check("three_layer_writes", total, 6);

    // Asynchronous reset while results are streaming.
    for (int i = 0; i < 4; i++) begin
      wrom[i] = DATA_W'(20 + i);
    end
    abuf[0] = 40;
    push_model(1, 4, 3);
    run_layer(1, 4, 3, -1, -1, 3, w);

    // Recovery after reset.
    load_rand(2, 3);
    push_model(2, 3, 9);
    run_layer(2, 3, 9, -1, -1, -1, w);
    check("recovery_writes", w, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
